// File: rtl/relock_pkg.sv
// Shared widths, state encoding and reset defaults for the relock controller.
package relock_pkg;
  localparam int DW       = 16;
  localparam int ACC_W    = 32;
  localparam int SETTLE_W = 27;

  typedef enum logic [1:0] {
    LOCKED   = 2'b00,
    UNLOCKED = 2'b01,
    SETTLING = 2'b10
  } state_e;

  localparam int                   DEF_CNT_SETTLE = 100_000_000;
  localparam logic signed [DW-1:0] DEF_THR_LO     = 16'sh2000;
  localparam logic signed [DW-1:0] DEF_THR_HI     = 16'sh2400;
  localparam logic [7:0]           DEF_DEBOUNCE   = 8'd4;
  localparam logic signed [DW-1:0] DEF_SWEEP_MIN  = 16'sh1800;
  localparam logic signed [DW-1:0] DEF_SWEEP_MAX  = 16'sh5400;
  localparam logic [ACC_W-1:0]     DEF_STEP       = 32'h0000_0080;
endpackage

// File: rtl/tri_sweep_acc.sv
// Triangle sweep accumulator (Q16.16) with bound clamping; advances only while run=1.
module tri_sweep_acc
  import relock_pkg::*;
#(
  parameter logic signed [DW-1:0] RST_MIN = DEF_SWEEP_MIN
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 run,
  input  logic signed [DW-1:0] min,
  input  logic signed [DW-1:0] max,
  input  logic [ACC_W-1:0]     step,
  output logic signed [DW-1:0] value
);
  localparam int FW = ACC_W - DW;

  logic signed [ACC_W-1:0] acc, acc_nxt, lo, hi;
  logic signed [ACC_W+1:0] acc_x, step_x, lo_x, hi_x, sum;
  logic                    dir_up, dir_nxt;

  assign lo     = {min, {FW{1'b0}}};
  assign hi     = {max, {FW{1'b0}}};
  assign acc_x  = (ACC_W+2)'(acc);
  assign lo_x   = (ACC_W+2)'(lo);
  assign hi_x   = (ACC_W+2)'(hi);
  // Two guard bits so a full-scale step can never wrap before the bound compare.
  assign step_x = $signed({2'b00, step});
  assign sum    = dir_up ? acc_x + step_x : acc_x - step_x;

  always_comb begin
    acc_nxt = acc;
    dir_nxt = dir_up;
    if (min > max) begin
      acc_nxt = lo;
    end else if (acc > hi) begin
      acc_nxt = hi;
      dir_nxt = 1'b0;
    end else if (acc < lo) begin
      acc_nxt = lo;
      dir_nxt = 1'b1;
    end else if (run) begin
      if (dir_up && sum >= hi_x) begin
        acc_nxt = hi;
        dir_nxt = 1'b0;
      end else if (!dir_up && sum <= lo_x) begin
        acc_nxt = lo;
        dir_nxt = 1'b1;
      end else begin
        acc_nxt = sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      acc    <= {RST_MIN, {FW{1'b0}}};
      dir_up <= 1'b1;
    end else begin
      acc    <= acc_nxt;
      dir_up <= dir_nxt;
    end
  end

  assign value = acc[ACC_W-1:FW];
endmodule

// File: rtl/relock_controller.sv
// Lock detector with hysteresis/debounce, settle timer, relock sweep and status LEDs.
module relock_controller
  import relock_pkg::*;
#(
  parameter int CNT_SETTLE = DEF_CNT_SETTLE
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic signed [DW-1:0] trans_in,
  input  logic signed [DW-1:0] thr_lo_in,
  input  logic signed [DW-1:0] thr_hi_in,
  input  logic [7:0]           debounce_in,
  input  logic signed [DW-1:0] sweep_min_in,
  input  logic signed [DW-1:0] sweep_max_in,
  input  logic [ACC_W-1:0]     stepsize_in,
  input  logic                 param_load_in,
  output logic                 relock_on_out,
  output logic signed [DW-1:0] sweep_out,
  output logic [1:0]           state_out,
  output logic                 locked_led_out,
  output logic                 unlocked_led_out,
  output logic                 settling_led_out
);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(CNT_SETTLE - 1);

  logic signed [DW-1:0] thr_lo, thr_hi, sweep_min, sweep_max, trans_q;
  logic [7:0]           debounce, deb_eff, deb_cnt, deb_cnt_nxt;
  logic [ACC_W-1:0]     step;
  logic [SETTLE_W-1:0]  settle_cnt, settle_cnt_nxt;
  state_e               state, state_nxt;
  logic                 lost, found, exit_cond, deb_done;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      thr_lo    <= DEF_THR_LO;
      thr_hi    <= DEF_THR_HI;
      debounce  <= DEF_DEBOUNCE;
      sweep_min <= DEF_SWEEP_MIN;
      sweep_max <= DEF_SWEEP_MAX;
      step      <= DEF_STEP;
      trans_q   <= '0;
    end else begin
      trans_q <= trans_in;
      if (param_load_in) begin
        thr_lo    <= thr_lo_in;
        thr_hi    <= thr_hi_in;
        debounce  <= debounce_in;
        sweep_min <= sweep_min_in;
        sweep_max <= sweep_max_in;
        step      <= stepsize_in;
      end
    end
  end

  assign lost      = trans_q < thr_lo;
  assign found     = trans_q >= thr_hi;
  assign deb_eff   = (debounce == 8'd0) ? 8'd1 : debounce;
  // deb_cnt holds prior qualifying cycles, so this cycle completes the run.
  assign deb_done  = deb_cnt >= deb_eff - 8'd1;
  assign exit_cond = (state == UNLOCKED) ? found : lost;

  always_comb begin
    state_nxt      = state;
    deb_cnt_nxt    = 8'd0;
    settle_cnt_nxt = '0;
    case (state)
      UNLOCKED: if (found && deb_done) state_nxt = SETTLING;
      SETTLING: begin
        if (lost && deb_done)               state_nxt = UNLOCKED;
        else if (settle_cnt == SETTLE_LAST) state_nxt = LOCKED;
        else settle_cnt_nxt = settle_cnt + SETTLE_W'(1);
      end
      LOCKED:   if (lost && deb_done) state_nxt = UNLOCKED;
      default:  state_nxt = UNLOCKED;
    endcase
    if (state_nxt == state && exit_cond)
      deb_cnt_nxt = (deb_cnt == 8'hFF) ? deb_cnt : deb_cnt + 8'd1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= UNLOCKED;
      deb_cnt          <= 8'd0;
      settle_cnt       <= '0;
      locked_led_out   <= 1'b1;
      unlocked_led_out <= 1'b1;
      settling_led_out <= 1'b1;
    end else begin
      state            <= state_nxt;
      deb_cnt          <= deb_cnt_nxt;
      settle_cnt       <= settle_cnt_nxt;
      locked_led_out   <= (state != LOCKED);
      unlocked_led_out <= (state != UNLOCKED);
      settling_led_out <= (state != SETTLING);
    end
  end

  assign relock_on_out = (state == UNLOCKED);
  assign state_out     = state;

  tri_sweep_acc #(.RST_MIN(DEF_SWEEP_MIN)) u_sweep (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .run    (state == UNLOCKED),
    .min    (sweep_min),
    .max    (sweep_max),
    .step   (step),
    .value  (sweep_out)
  );
endmodule

// File: tb/tb_relock_controller.sv
// Directed bench for relock_controller with a shortened settle interval.
module tb_relock_controller;
  logic               clk_in = 1'b0;
  logic               rst_in = 1'b1;
  logic signed [15:0] trans_in = '0;
  logic signed [15:0] thr_lo_in = '0, thr_hi_in = '0, sweep_min_in = '0, sweep_max_in = '0;
  logic [7:0]         debounce_in = '0;
  logic [31:0]        stepsize_in = '0;
  logic               param_load_in = 1'b0;
  logic               relock_on_out;
  logic signed [15:0] sweep_out;
  logic [1:0]         state_out;
  logic               locked_led_out, unlocked_led_out, settling_led_out;
  int                 checks = 0, failures = 0;

  localparam logic [1:0] S_LOCKED = 2'b00, S_UNLOCKED = 2'b01, S_SETTLING = 2'b10;

  relock_controller #(.CNT_SETTLE(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .trans_in(trans_in),
    .thr_lo_in(thr_lo_in), .thr_hi_in(thr_hi_in), .debounce_in(debounce_in),
    .sweep_min_in(sweep_min_in), .sweep_max_in(sweep_max_in), .stepsize_in(stepsize_in),
    .param_load_in(param_load_in), .relock_on_out(relock_on_out), .sweep_out(sweep_out),
    .state_out(state_out), .locked_led_out(locked_led_out),
    .unlocked_led_out(unlocked_led_out), .settling_led_out(settling_led_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset;
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  task automatic load(input logic [7:0] deb, input logic signed [15:0] mn,
                      input logic signed [15:0] mx, input logic [31:0] st);
    thr_lo_in = 16'sh2000; thr_hi_in = 16'sh2400; debounce_in = deb;
    sweep_min_in = mn; sweep_max_in = mx; stepsize_in = st;
    param_load_in = 1'b1;
    tick();
    param_load_in = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (state_out !== S_UNLOCKED) begin failures++; $display("FAIL rst_state got=%b exp=01", state_out); end
    checks++; if (relock_on_out !== 1'b1) begin failures++; $display("FAIL rst_relock got=%b exp=1", relock_on_out); end
    checks++; if ({locked_led_out, unlocked_led_out, settling_led_out} !== 3'b111) begin failures++; $display("FAIL rst_leds got=%b exp=111", {locked_led_out, unlocked_led_out, settling_led_out}); end
    checks++; if (sweep_out !== 16'sh1800) begin failures++; $display("FAIL rst_sweep got=%h exp=1800", sweep_out); end
    tick();
    checks++; if ({locked_led_out, unlocked_led_out, settling_led_out} !== 3'b101) begin failures++; $display("FAIL post_rst_leds got=%b exp=101", {locked_led_out, unlocked_led_out, settling_led_out}); end
  endtask

  task automatic test_hysteresis;
    do_reset();
    trans_in = 16'sh2200;
    repeat (10) tick();
    checks++; if (state_out !== S_UNLOCKED) begin failures++; $display("FAIL hyst_unlocked got=%b exp=01", state_out); end
    trans_in = 16'sh3000;
    tick();
    repeat (3) tick();
    checks++; if (state_out !== S_UNLOCKED) begin failures++; $display("FAIL hyst_edge3 got=%b exp=01", state_out); end
    tick();
    checks++; if (state_out !== S_SETTLING) begin failures++; $display("FAIL hyst_edge4 got=%b exp=10", state_out); end
    checks++; if (relock_on_out !== 1'b0) begin failures++; $display("FAIL hyst_relock got=%b exp=0", relock_on_out); end
  endtask

  task automatic test_settle_drop;
    repeat (15) tick();
    checks++; if (state_out !== S_SETTLING) begin failures++; $display("FAIL settle_15 got=%b exp=10", state_out); end
    checks++; if (settling_led_out !== 1'b0) begin failures++; $display("FAIL settle_led got=%b exp=0", settling_led_out); end
    tick();
    checks++; if (state_out !== S_LOCKED) begin failures++; $display("FAIL settle_16 got=%b exp=00", state_out); end
    tick();
    checks++; if ({locked_led_out, unlocked_led_out, settling_led_out} !== 3'b011) begin failures++; $display("FAIL locked_leds got=%b exp=011", {locked_led_out, unlocked_led_out, settling_led_out}); end
    trans_in = 16'sh2200;
    repeat (10) tick();
    checks++; if (state_out !== S_LOCKED) begin failures++; $display("FAIL hyst_locked got=%b exp=00", state_out); end
    trans_in = 16'sh1000;
    repeat (3) tick();
    trans_in = 16'sh3000;
    repeat (6) tick();
    checks++; if (state_out !== S_LOCKED) begin failures++; $display("FAIL dip3 got=%b exp=00", state_out); end
    trans_in = 16'sh1000;
    repeat (4) tick();
    trans_in = 16'sh3000;
    checks++; if (state_out !== S_LOCKED) begin failures++; $display("FAIL dip4_pre got=%b exp=00", state_out); end
    tick();
    checks++; if (state_out !== S_UNLOCKED) begin failures++; $display("FAIL dip4 got=%b exp=01", state_out); end
    checks++; if (relock_on_out !== 1'b1 || unlocked_led_out !== 1'b1) begin failures++; $display("FAIL dip4_outs got=%b%b exp=11", relock_on_out, unlocked_led_out); end
    tick();
    checks++; if (unlocked_led_out !== 1'b0) begin failures++; $display("FAIL dip4_led got=%b exp=0", unlocked_led_out); end
  endtask

  task automatic test_sweep_and_hold;
    logic signed [15:0] exp_seq [10];
    exp_seq = '{16'sh10, 16'sh11, 16'sh12, 16'sh13, 16'sh14, 16'sh13, 16'sh12, 16'sh11, 16'sh10, 16'sh11};
    trans_in = 16'sh0000;
    do_reset();
    load(8'd4, 16'sh0010, 16'sh0000, 32'h0001_0000);
    repeat (3) tick();
    checks++; if (sweep_out !== 16'sh0010) begin failures++; $display("FAIL min_gt_max got=%h exp=0010", sweep_out); end
    load(8'd4, 16'sh0010, 16'sh0014, 32'h0001_0000);
    for (int i = 0; i < 10; i++) begin
      checks++; if (sweep_out !== exp_seq[i]) begin failures++; $display("FAIL sweep_seq[%0d] got=%h exp=%h", i, sweep_out, exp_seq[i]); end
      if (i == 5) trans_in = 16'sh3000;
      tick();
    end
    checks++; if (state_out !== S_SETTLING || sweep_out !== 16'sh0012) begin failures++; $display("FAIL capture got=%b/%h exp=10/0012", state_out, sweep_out); end
    repeat (2) tick();
    trans_in = 16'sh1000;
    repeat (4) tick();
    checks++; if (sweep_out !== 16'sh0012) begin failures++; $display("FAIL hold got=%h exp=0012", sweep_out); end
    tick();
    checks++; if (state_out !== S_UNLOCKED || sweep_out !== 16'sh0012) begin failures++; $display("FAIL reenter got=%b/%h exp=01/0012", state_out, sweep_out); end
    tick();
    checks++; if (sweep_out !== 16'sh0013) begin failures++; $display("FAIL resume got=%h exp=0013", sweep_out); end
  endtask

  task automatic test_param_clamp;
    do_reset();
    trans_in = 16'sh3000;
    load(8'd4, 16'sh5000, 16'sh7000, 32'h0);
    tick();
    checks++; if (sweep_out !== 16'sh5000) begin failures++; $display("FAIL clamp_lo got=%h exp=5000", sweep_out); end
    repeat (24) tick();
    checks++; if (state_out !== S_LOCKED || sweep_out !== 16'sh5000) begin failures++; $display("FAIL clamp_locked got=%b/%h exp=00/5000", state_out, sweep_out); end
    load(8'd4, 16'sh1000, 16'sh4000, 32'h0);
    checks++; if (sweep_out !== 16'sh5000) begin failures++; $display("FAIL clamp_pre got=%h exp=5000", sweep_out); end
    tick();
    checks++; if (sweep_out !== 16'sh4000 || state_out !== S_LOCKED) begin failures++; $display("FAIL clamp_hi got=%h/%b exp=4000/00", sweep_out, state_out); end
    load(8'd4, 16'sh6000, 16'sh4000, 32'h0);
    tick();
    checks++; if (sweep_out !== 16'sh6000) begin failures++; $display("FAIL clamp_inv got=%h exp=6000", sweep_out); end
  endtask

  task automatic test_mid_reset;
    rst_in = 1'b1;
    tick();
    checks++; if (state_out !== S_UNLOCKED || sweep_out !== 16'sh1800 || relock_on_out !== 1'b1) begin failures++; $display("FAIL midrst got=%b/%h/%b exp=01/1800/1", state_out, sweep_out, relock_on_out); end
    checks++; if ({locked_led_out, unlocked_led_out, settling_led_out} !== 3'b111) begin failures++; $display("FAIL midrst_leds got=%b exp=111", {locked_led_out, unlocked_led_out, settling_led_out}); end
    rst_in = 1'b0;
    repeat (2) tick();
    checks++; if (sweep_out !== 16'sh1800) begin failures++; $display("FAIL midrst_shadow got=%h exp=1800", sweep_out); end
  endtask

  task automatic test_lost_vs_settle;
    do_reset();
    trans_in = 16'sh3000;
    tick();
    repeat (4) tick();
    checks++; if (state_out !== S_SETTLING) begin failures++; $display("FAIL simul_entry got=%b exp=10", state_out); end
    repeat (11) tick();
    trans_in = 16'sh1000;
    repeat (4) tick();
    checks++; if (state_out !== S_SETTLING) begin failures++; $display("FAIL simul_pre got=%b exp=10", state_out); end
    tick();
    checks++; if (state_out !== S_UNLOCKED) begin failures++; $display("FAIL simul_prio got=%b exp=01", state_out); end
  endtask

  task automatic test_debounce_zero;
    do_reset();
    trans_in = 16'sh3000;
    load(8'd0, 16'sh1800, 16'sh5400, 32'h80);
    checks++; if (state_out !== S_UNLOCKED) begin failures++; $display("FAIL deb0_pre got=%b exp=01", state_out); end
    tick();
    checks++; if (state_out !== S_SETTLING) begin failures++; $display("FAIL deb0 got=%b exp=10", state_out); end
  endtask

  initial begin
    test_reset();
    test_hysteresis();
    test_settle_drop();
    test_sweep_and_hold();
    test_param_clamp();
    test_mid_reset();
    test_lost_vs_settle();
    test_debounce_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
